// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider (signed/unsigned) producing {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration when |dividend| < |divisor|.
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, FINISH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] rem_q, quot_q, dvs_q;
    logic          signed_q, a_neg_q, b_neg_q, early_q;

    logic          a_neg_c, b_neg_c, early_c, qbit_c;
    logic [DW-1:0] mag_a_c, mag_b_c, quot_fix_c, rem_fix_c;
    logic [DW:0]   rem_shift_c, diff_c;

    // Operand magnitudes for the unsigned core
    assign a_neg_c = signed_div_i & opdata1_i[DW-1];
    assign b_neg_c = signed_div_i & opdata2_i[DW-1];
    assign mag_a_c = a_neg_c ? (~opdata1_i + DW'(1)) : opdata1_i;
    assign mag_b_c = b_neg_c ? (~opdata2_i + DW'(1)) : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
    assign early_c = (mag_a_c < mag_b_c);
`else
    assign early_c = 1'b0;
`endif

    // One restoring step: dividend bits shift out of quot_q while quotient bits shift in
    assign rem_shift_c = {rem_q, quot_q[DW-1]};
    assign diff_c      = rem_shift_c - {1'b0, dvs_q};
    assign qbit_c      = ~diff_c[DW];

    // Sign correction; negation wraps at 32 bits so 0x80000000 / -1 needs no special case
    assign quot_fix_c = (signed_q & (a_neg_q ^ b_neg_q)) ? (~quot_q + DW'(1)) : quot_q;
    assign rem_fix_c  = (signed_q & a_neg_q) ? (~rem_q + DW'(1)) : rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = annul_i ? DIVZERO : BUSY;
            DIVZERO: state_d = start_i ? FINISH : IDLE;
            BUSY: begin
                if (!start_i)                               state_d = IDLE;
                else if (early_q || cnt_q == CW'(DW - 1))   state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvs_q    <= '0;
            signed_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            early_q  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            ready_o <= (state_q == FINISH);
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cnt_q <= '0;
                        rem_q <= '0;
                        if (annul_i) begin
                            // Zero operands make the FINISH load produce 64'h0
                            quot_q   <= '0;
                            dvs_q    <= '0;
                            signed_q <= 1'b0;
                            a_neg_q  <= 1'b0;
                            b_neg_q  <= 1'b0;
                            early_q  <= 1'b0;
                        end else begin
                            quot_q   <= mag_a_c;
                            dvs_q    <= mag_b_c;
                            signed_q <= signed_div_i;
                            a_neg_q  <= a_neg_c;
                            b_neg_q  <= b_neg_c;
                            early_q  <= early_c;
                        end
                    end
                end
                BUSY: begin
                    if (start_i) begin
                        if (early_q) begin
                            rem_q  <= quot_q;
                            quot_q <= '0;
                        end else begin
                            rem_q  <= qbit_c ? diff_c[DW-1:0] : rem_shift_c[DW-1:0];
                            quot_q <= {quot_q[DW-2:0], qbit_c};
                            cnt_q  <= cnt_q + CW'(1);
                        end
                    end
                end
                FINISH:  result_o <= {rem_fix_c, quot_fix_c};
                default: ;
            endcase
        end
    end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled on accept.
REQ-004 SHALL have port: opdata1_i  input  32  dividend; sampled on accept.
REQ-005 SHALL have port: opdata2_i  input  32  divisor; sampled on accept.
REQ-006 SHALL have port: start_i  input  1  request; held high by ALU until ready_o seen.
REQ-007 SHALL have port: annul_i  input  1  divisor-is-zero flag from ALU; sampled on accept.
REQ-008 SHALL have port: result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}, registered.
REQ-009 SHALL have port: ready_o  output  1  result valid, registered, one-cycle pulse.

Function
REQ-010 SHALL implement FSM states IDLE, DIVZERO, BUSY, FINISH.
REQ-011 IDLE: start_i=1 and annul_i=1 -> DIVZERO; start_i=1 and annul_i=0 -> BUSY (accept edge); else stay.
REQ-012 On accept SHALL latch operand magnitudes (two's-complement negate negative operands when signed_div_i=1), sign flags and signed_div_i; clear 6-bit iteration counter.
REQ-013 BUSY: one restoring-division step per cycle (shift partial remainder left, subtract divisor magnitude, set quotient bit if non-negative); exactly 32 steps, then -> FINISH.
REQ-014 Latency: ready_o high in the 33rd cycle after the accept edge; no pipelining, one divide in flight.
REQ-015 FINISH: result_o loaded with sign-corrected results, ready_o=1 for exactly one cycle, then -> IDLE regardless of start_i.
REQ-016 Signed correction: quotient negated when dividend and divisor signs differ; remainder takes dividend sign; width wraps at 32 bits.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-018 DIVZERO: one cycle, then -> FINISH with result_o = 64'h0.
REQ-019 start_i low in BUSY or DIVZERO SHALL abort to IDLE next edge, no ready_o pulse, result_o unchanged (pipeline flush).
REQ-020 start_i high during FINISH SHALL NOT start a new divide; a new accept requires IDLE.
REQ-021 Operand inputs changing in BUSY SHALL have no effect on the result.
REQ-022 result_o SHALL hold its last value outside FINISH load.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, ready_o=0, result_o=64'h0, counter=0, independent of clk.
REQ-024 rst asserted mid-divide SHALL discard the operation; no ready_o after release until a new accept.

Configuration
REQ-025 Macro DIV_EARLY_OUT_EN: when defined, an accept with dividend magnitude < divisor magnitude SHALL skip BUSY and go to FINISH next edge with quotient 0, remainder = original dividend (ready_o 2 cycles after accept).
REQ-026 Without DIV_EARLY_OUT_EN every non-zero-divisor divide SHALL take the full 32 steps of REQ-014.

Verification
REQ-027 Unsigned 100 / 7 (signed_div_i=0) -> ready_o in cycle 33, result_o = 64'h00000002_0000000E.
REQ-028 Signed 0xFFFFFFF9 / 2 -> result_o = 64'hFFFFFFFF_FFFFFFFD; signed 0x80000000 / 0xFFFFFFFF -> 64'h00000000_80000000.
REQ-029 Divide with opdata2_i=0, annul_i=1 -> ready_o 2 cycles after accept, result_o = 64'h0.
REQ-030 Drop start_i at BUSY step 10 -> IDLE next cycle, no ready_o within 40 cycles, result_o unchanged.
REQ-031 Assert rst at BUSY step 20, release, then 9/3 unsigned -> result_o = 64'h0 during reset, then 64'h00000000_00000003 after 33 cycles.
REQ-032 3 / 10 unsigned -> with DIV_EARLY_OUT_EN ready_o at cycle 2, else cycle 33; result_o = 64'h00000003_00000000 both.
